// File: rtl/adc_serial_reader.sv
`timescale 1ns/1ps
// adc_serial_reader
// SPI-style master for the microphone ADC. The link is CPOL=1 with one
// FRAME_BITS-clock frame per conversion. Each frame carries leading zero bits
// followed by DATA_BITS data bits, MSB first. One conversion is started every
// SAMPLE_PERIOD clk cycles while enable is high. The result is presented on a
// valid/ready interface.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   enable        1 = run periodic conversions
//   adc_cs        ADC chip select, active low
//   adc_clk       ADC serial clock, idles high
//   adc_sd        ADC serial data (the ADC changes it on adc_clk falling edges)
//   sample        last completed conversion, unsigned
//   sample_valid  sample holds unconsumed data
//   sample_ready  consumer accepts sample when sample_valid & sample_ready
//   overrun       1-cycle pulse: a new sample overwrote an unconsumed one
//   frame_err     1-cycle pulse with a new sample whose leading bits were not 0
//
// State table
//   S_IDLE  | cs high, clk high, waiting for a period tick
//   S_SETUP | cs low, clk high for CLK_DIV cycles (chip-select setup)
//   S_SHIFT | FRAME_BITS adc_clk periods, CLK_DIV cycles low then CLK_DIV high
//   S_HOLD  | cs high, clk high for CLK_DIV cycles (quiet time before IDLE)
module adc_serial_reader #(
    parameter int CLK_DIV       = 5,
    parameter int FRAME_BITS    = 16,
    parameter int DATA_BITS     = 12,
    parameter int SAMPLE_PERIOD = 1250
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic                 adc_cs,
    output logic                 adc_clk,
    input  logic                 adc_sd,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun,
    output logic                 frame_err
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

    state_t                  state, state_n;
    logic [DIV_W-1:0]        div_cnt, div_cnt_n;
    logic [BIT_W-1:0]        bit_cnt, bit_cnt_n;
    logic [PER_W-1:0]        per_cnt, per_cnt_n;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic                    adc_cs_n, adc_clk_n;
    logic                    start, div_tc, capture, load, lead_err;

    // Period counter is held at 0 while disabled, so re-enabling starts a
    // frame on the very next edge.
    always_comb begin
        per_cnt_n = per_cnt + PER_W'(1);
        if (!enable || per_cnt == PER_LAST) begin
            per_cnt_n = '0;
        end
    end

    assign start    = enable && (per_cnt == '0) && (state == S_IDLE);
    assign div_tc   = (div_cnt == '0);
    assign lead_err = ((shift_reg >> DATA_BITS) != '0);

    always_comb begin
        state_n   = state;
        div_cnt_n = div_cnt;
        bit_cnt_n = bit_cnt;
        adc_cs_n  = adc_cs;
        adc_clk_n = adc_clk;
        capture   = 1'b0;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n   = S_SETUP;
                    div_cnt_n = DIV_LOAD;
                    adc_cs_n  = 1'b0;
                    adc_clk_n = 1'b1;
                end
            end
            S_SETUP: begin
                if (div_tc) begin
                    state_n   = S_SHIFT;
                    div_cnt_n = DIV_LOAD;
                    bit_cnt_n = '0;
                    adc_clk_n = 1'b0;
                end else begin
                    div_cnt_n = div_cnt - DIV_W'(1);
                end
            end
            S_SHIFT: begin
                if (!div_tc) begin
                    div_cnt_n = div_cnt - DIV_W'(1);
                end else if (!adc_clk) begin
                    // Rising adc_clk: data has been stable for half a bit.
                    adc_clk_n = 1'b1;
                    capture   = 1'b1;
                    div_cnt_n = DIV_LOAD;
                end else if (bit_cnt == LAST_BIT) begin
                    state_n   = S_HOLD;
                    adc_cs_n  = 1'b1;
                    div_cnt_n = DIV_LOAD;
                    load      = 1'b1;
                end else begin
                    adc_clk_n = 1'b0;
                    bit_cnt_n = bit_cnt + BIT_W'(1);
                    div_cnt_n = DIV_LOAD;
                end
            end
            S_HOLD: begin
                if (div_tc) begin
                    state_n = S_IDLE;
                end else begin
                    div_cnt_n = div_cnt - DIV_W'(1);
                end
            end
            default: begin
                state_n  = S_IDLE;
                adc_cs_n = 1'b1;
                adc_clk_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            per_cnt   <= '0;
            adc_cs    <= 1'b1;
            adc_clk   <= 1'b1;
            shift_reg <= '0;
        end else begin
            state   <= state_n;
            div_cnt <= div_cnt_n;
            bit_cnt <= bit_cnt_n;
            per_cnt <= per_cnt_n;
            adc_cs  <= adc_cs_n;
            adc_clk <= adc_clk_n;
            if (capture) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], adc_sd};
            end
        end
    end

    // A new sample always wins over a coincident consume, so valid stays set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
        end else if (load) begin
            sample       <= shift_reg[DATA_BITS-1:0];
            sample_valid <= 1'b1;
            overrun      <= sample_valid && !sample_ready;
            frame_err    <= lead_err;
        end else begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule
